// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - MIPS program counter and instruction fetch stage
// Fetches over a ready handshake, executes until instr_done, then selects the next PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_done,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm,
    input  logic        jump,
    input  logic [31:0] jump_address,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        halted_q, halted_d;
    logic [31:0] next_pc;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign halted      = halted_q;

    // Next-PC select: jr over jump over branch over sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_address;
        end else if (branch_taken) begin
            next_pc = pc_plus4 + {branch_imm[29:0], 2'b00};
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        halted_d    = halted_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (instr_done) begin
                    // Only a register target can be misaligned; stop rather than fetch it.
                    if (next_pc[1:0] != 2'b00) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_VECTOR;
            instr_q  <= 32'h0000_0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_done;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic [31:0] branch_imm;
    logic        jump;
    logic [31:0] jump_address;
    logic        jr;
    logic [31:0] jr_target;
    logic        halted;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference: phase 0 = waiting for instruction, 1 = executing, 2 = halted.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid),
        .instr_done(instr_done), .pc(pc), .pc_plus4(pc_plus4),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump(jump), .jump_address(jump_address),
        .jr(jr), .jr_target(jr_target), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] cur);
        longint unsigned t;
        if (jr) return jr_target;
        if (jump) return jump_address;
        if (branch_taken) begin
            t = longint'(cur) + 4 + longint'(branch_imm) * 4;
            return t[31:0];
        end
        t = longint'(cur) + 4;
        return t[31:0];
    endfunction

    always @(posedge clk) begin
        logic [31:0] tgt;
        if (reset) begin
            m_phase <= 0;
            m_pc    <= RV;
            m_instr <= 32'h0;
        end else if (m_phase == 0) begin
            if (imem_ready) begin
                m_instr <= imem_rdata;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (instr_done) begin
                tgt = model_target(m_pc);
                if (tgt % 4 != 0) begin
                    m_phase <= 2;
                end else begin
                    m_pc    <= tgt;
                    m_phase <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_req", imem_req, m_phase == 0);
            if (m_phase == 0) chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", instr_valid, m_phase == 1);
            chk("instruction", instruction, m_instr);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("halted", halted, m_phase == 2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sel();
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jr_target = 32'h0; jump_address = 32'h0; branch_imm = 32'h0;
    endtask

    // Precondition: fetching with imem_ready=1 and instr_done=1.
    task automatic exec_with(input logic j_r, input logic [31:0] jt, input logic j,
                             input logic [31:0] ja, input logic br, input logic [31:0] imm);
        cyc();
        jr = j_r; jr_target = jt; jump = j; jump_address = ja;
        branch_taken = br; branch_imm = imm;
        cyc();
        clear_sel();
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; instr_done = 1'b0;
        clear_sel();
        cyc();
        cmp_en = 1'b1;
        chk("rst_req", imem_req, 1'b1);
        chk("rst_pc", pc, RV);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_instr", instruction, 32'h0);

        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0; instr_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("seq_req", imem_req, (i % 2) == 0);
            if (i % 2 == 0) chk("seq_addr", imem_addr, 32'(i * 2));
            if (i < 5) cyc();
        end

        // Currently executing at 0x8: redirect to 0x0040_0010.
        jr = 1'b1; jr_target = 32'h0040_0010;
        cyc();
        clear_sel();
        chk("jr_set_pc", imem_addr, 32'h0040_0010);
        exec_with(1'b0, 32'h0, 1'b1, 32'h0040_0100, 1'b1, 32'h5);
        chk("jump_over_branch", imem_addr, 32'h0040_0100);

        exec_with(1'b1, 32'h0000_0020, 1'b0, 32'h0, 1'b0, 32'h0);
        exec_with(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE);
        chk("branch_back", pc, 32'h0000_001C);
        exec_with(1'b1, 32'h0000_0020, 1'b0, 32'h0, 1'b0, 32'h0);
        exec_with(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0003);
        chk("branch_fwd", pc, 32'h0000_0030);

        exec_with(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        chk("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
        exec_with(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq_wrap", imem_addr, 32'h0000_0000);

        // Wait states: address stable, instr_valid one cycle after ready.
        imem_ready = 1'b0; instr_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("wait_addr", imem_addr, 32'h0);
            chk("wait_valid", instr_valid, 1'b0);
        end
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        chk("wait_valid_rise", instr_valid, 1'b1);
        chk("wait_instr", instruction, 32'h1234_5678);
        imem_ready = 1'b0; instr_done = 1'b1;
        cyc();
        instr_done = 1'b0;
        cyc();
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("rst_fetch_instr", instruction, 32'h0);
        chk("rst_fetch_valid", instr_valid, 1'b0);
        chk("rst_fetch_pc", imem_addr, RV);
        reset = 1'b0; imem_ready = 1'b0;
        cyc();
        chk("rst_fetch_noexec", instr_valid, 1'b0);

        // Misaligned jr halts with pc held.
        imem_ready = 1'b1; instr_done = 1'b1; imem_rdata = 32'h0;
        exec_with(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0);
        exec_with(1'b1, 32'h0000_0042, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("halt_flag", halted, 1'b1);
            chk("halt_pc", pc, 32'h0000_0100);
            chk("halt_req", imem_req, 1'b0);
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("halt_rst_flag", halted, 1'b0);
        chk("halt_rst_pc", pc, RV);

        for (int n = 0; n < 4000; n++) begin
            reset        = (m_phase == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            imem_ready   = $urandom_range(0, 1) == 1;
            imem_rdata   = $urandom;
            instr_done   = $urandom_range(0, 1) == 1;
            jr           = $urandom_range(0, 5) == 0;
            jr_target    = $urandom;
            if ($urandom_range(0, 19) != 0) jr_target[1:0] = 2'b00;
            jump         = $urandom_range(0, 3) == 0;
            jump_address = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            branch_taken = $urandom_range(0, 2) == 0;
            branch_imm   = {{16{$urandom_range(0, 1) == 1}}, 16'($urandom)};
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
